// File: rtl/eq_band_scheduler.sv
// Shares one fixed-latency band pipeline across NUM_BANDS equalizer bands:
// issues each accepted sample once per band, re-tags returns, emits per-band results.
module eq_band_scheduler #(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_BANDS    = 4,
  parameter int PIPE_LATENCY = 3,
  localparam int BAND_W      = $clog2(NUM_BANDS)
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic                  sample_ready_o,
  output logic                  issue_valid_o,
  output logic [BAND_W-1:0]     issue_band_o,
  output logic [DATA_WIDTH-1:0] issue_data_o,
  input  logic [DATA_WIDTH-1:0] ret_data_i,
  output logic                  result_valid_o,
  output logic [BAND_W-1:0]     result_band_o,
  output logic [DATA_WIDTH-1:0] result_data_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                              state;
  logic [BAND_W-1:0]                   band_cnt;
  logic [DATA_WIDTH-1:0]               sample_lat;
  logic [PIPE_LATENCY-1:0][BAND_W:0]   tags;
  logic [BAND_W:0]                     tag_in;
  logic                                tail_valid;
  logic [BAND_W-1:0]                   tail_band;
  logic                                any_valid;

  assign sample_ready_o = (state == IDLE);
  assign busy_o         = (state != IDLE);
  assign frame_done_o   = (state == DONE);
  assign issue_valid_o  = (state == ISSUE);
  assign issue_band_o   = band_cnt;
  assign issue_data_o   = sample_lat;

  // Each tag entry mirrors one slot of the tagless shared pipeline: {valid, band}.
  assign tag_in     = {issue_valid_o, issue_band_o};
  assign tail_valid = tags[PIPE_LATENCY-1][BAND_W];
  assign tail_band  = tags[PIPE_LATENCY-1][BAND_W-1:0];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      any_valid = any_valid | tags[i][BAND_W];
    end
  end

  if (PIPE_LATENCY == 1) begin : g_shift1
    always_ff @(posedge clk_i) begin
      if (clr_i) tags <= '0;
      else       tags <= tag_in;
    end
  end else begin : g_shiftn
    always_ff @(posedge clk_i) begin
      if (clr_i) tags <= '0;
      else       tags <= {tags[PIPE_LATENCY-2:0], tag_in};
    end
  end

  // ret_data_i is only captured when the tail tag says a real band is returning.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      result_valid_o <= 1'b0;
      result_band_o  <= '0;
      result_data_o  <= '0;
    end else begin
      result_valid_o <= tail_valid;
      if (tail_valid) begin
        result_band_o <= tail_band;
        result_data_o <= ret_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state      <= IDLE;
      band_cnt   <= '0;
      sample_lat <= '0;
      overrun_o  <= 1'b0;
    end else begin
      if (sample_valid_i && state != IDLE) overrun_o <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid_i) begin
            sample_lat <= sample_i;
            band_cnt   <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Counter holds at the last band instead of wrapping.
          if (band_cnt == BAND_W'(NUM_BANDS - 1)) state <= DRAIN;
          else band_cnt <= band_cnt + 1'b1;
        end
        DRAIN: begin
          if (!any_valid) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eq_band_scheduler.md
Name: eq_band_scheduler

Overview:
- Time-multiplexes one shared fixed-latency band pipeline across NUM_BANDS equalizer bands.
- The shared pipeline is a chain of DFlop registers plus arithmetic with no valid/tag of its own.
- Per audio sample: accepts the sample, issues it once per band on consecutive cycles, and tracks in-flight band tags internally.
- Re-tags returning pipeline data, emits one result per band, pulses frame_done_o when the frame is complete, and flags overrun if a sample arrives while busy.

Parameters:
- DATA_WIDTH, 24, sample and result width in bits.
- NUM_BANDS, 4, bands per sample (>=2).
- PIPE_LATENCY, 3, cycles from issue to valid ret_data_i in the shared pipeline (>=1).
- BAND_W, $clog2(NUM_BANDS), band index width (derived, not overridden).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- clr_i  in  1  reset, synchronous, active-high.
- sample_valid_i  in  1  new input sample present.
- sample_i  in  DATA_WIDTH  input sample.
- sample_ready_o  out  1  scheduler idle; sample accepted this cycle if valid.
- issue_valid_o  out  1  issue_data_o/issue_band_o drive the shared pipeline this cycle.
- issue_band_o  out  BAND_W  band index being issued (coefficient select).
- issue_data_o  out  DATA_WIDTH  latched sample fed to the pipeline.
- ret_data_i  in  DATA_WIDTH  pipeline output; meaningful exactly PIPE_LATENCY cycles after an issue.
- result_valid_o  out  1  result_band_o/result_data_o valid (one-cycle pulse per band).
- result_band_o  out  BAND_W  band tag of the result.
- result_data_o  out  DATA_WIDTH  registered ret_data_i.
- frame_done_o  out  1  one-cycle pulse once all bands of the frame are output.
- busy_o  out  1  high in every state except IDLE.
- overrun_o  out  1  sticky: a sample arrived while not IDLE.

Behaviour:
- Reset (clr_i=1 at an edge), from any state including mid-frame:
  - FSM goes to IDLE; band counter, sample latch, tag/valid shift register and all outputs go to 0.
  - sample_ready_o is combinational (=1 in IDLE), so it reads 1 after reset.
  - In-flight pipeline returns are discarded: the valid pipe is cleared, so no result_valid_o follows reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - sample_ready_o=1.
  - On sample_valid_i: latch sample_i, set band counter to 0, go to ISSUE.
- ISSUE:
  - issue_valid_o=1, issue_band_o=counter, issue_data_o=latched sample.
  - Counter increments each cycle.
  - Exactly NUM_BANDS consecutive issue cycles (bands 0..NUM_BANDS-1, ascending); after band NUM_BANDS-1, go to DRAIN.
- Tracking:
  - Shift register of depth PIPE_LATENCY carrying {valid, band}, advanced every cycle and loaded with {issue_valid_o, issue_band_o}.
  - When its tail is valid, sample ret_data_i. Next cycle: result_valid_o=1, result_band_o=tail band, result_data_o=sampled ret_data_i.
  - Band issued at cycle t appears at result_valid_o at cycle t+PIPE_LATENCY+1.
  - ret_data_i is ignored when the tail is invalid.
- DRAIN:
  - Wait until the shift register holds no valid entries and the last result has been output.
  - Then go to DONE.
- DONE:
  - frame_done_o=1 for one cycle, in the cycle after result_band_o=NUM_BANDS-1 is output.
  - Next state is IDLE.
- Frame timing:
  - Sample accepted at cycle a → first issue at a+1, last result at a+NUM_BANDS+PIPE_LATENCY+1, frame_done_o at a+NUM_BANDS+PIPE_LATENCY+2.
  - Earliest next accept is a+NUM_BANDS+PIPE_LATENCY+3.
- Results are contiguous: NUM_BANDS consecutive result_valid_o cycles, in ascending band order, no gaps.
- Overrun:
  - sample_valid_i=1 in ISSUE, DRAIN or DONE sets overrun_o=1 the next cycle; that sample is dropped.
  - The current frame is unaffected.
  - overrun_o is cleared only by clr_i.
- Simultaneous events:
  - clr_i=1 together with sample_valid_i → reset wins; sample not accepted, overrun_o stays 0.
- No arithmetic in this block. The band counter wraps never; it is bounded by the FSM.
- Counter and tag widths are BAND_W. BAND_W=1 when NUM_BANDS=2.

Test Plan:
- Bench models the pipeline as ret = issue_data + issue_band, delayed PIPE_LATENCY cycles; defaults throughout.
- Single sample:
  - Stimulus: sample_i=0x000100 accepted at cycle 0.
  - Required: issue_valid_o at cycles 1-4 with bands 0,1,2,3; result_valid_o at cycles 5-8 with data 0x000100,0x000101,0x000102,0x000103 and bands 0-3; frame_done_o at cycle 9; sample_ready_o=1 again at cycle 10.
- Back-to-back:
  - Stimulus: sample_valid_i held high continuously with 0x000010 then 0x000020.
  - Required: second sample accepted at cycle 10; overrun_o=1 from cycle 2; second frame results 0x000020-0x000023.
- Reset mid-frame:
  - Stimulus: clr_i=1 at cycle 3 of a frame.
  - Required: all outputs 0 at cycle 4; no result_valid_o for the next 10 cycles; sample_ready_o=1 from cycle 4; overrun_o=0.
- Parameter sweep:
  - Stimulus: NUM_BANDS=2, PIPE_LATENCY=1 and NUM_BANDS=8, PIPE_LATENCY=5.
  - Required: frame_done_o at a+NUM_BANDS+PIPE_LATENCY+2; results contiguous and in ascending band order.
- Reset vs. sample:
  - Stimulus: clr_i and sample_valid_i both high in one cycle.
  - Required: no issue follows, busy_o=0, overrun_o=0.
- Garbage rejection:
  - Stimulus: ret_data_i driven with random data while idle.
  - Required: result_valid_o never asserts.
